calc1_port_sequencer: RTL and testbench
=======================================

// Module: calc1_port_sequencer
// PURPOSE
//  Upstream feeder for one calc1 request port. Takes whole operations
//  (cmd, op1, op2, tag) over a valid/ready interface. Serialises each one
//  into calc1's two-cycle protocol: cmd+op1 on the first cycle, then
//  cmd=0 with op2 on the second. Waits for calc1's out_respN, then returns
//  the result with its tag over a second valid/ready interface.
//  One instance per calc1 port, so four per DUV.
// PARAMETERS
//  TIMEOUT  64  WAIT-state cycles before a missing response is declared; 2..2**16-1
//  CNT_W    16  width of the completion and timeout statistics counters
// PORTS
//  c_clk          in   1    single clock; all logic on rising edge
//  reset          in   1    synchronous, active-high reset
//  req_valid      in   1    request offered
//  req_ready      out  1    sequencer can accept a request
//  req_cmd        in   [0:3] calc1 command (1 add, 2 sub, 5 shl, 6 shr; 0 no-op)
//  req_op1        in   [0:31] first operand
//  req_op2        in   [0:31] second operand
//  req_tag        in   [0:1] opaque tag, returned unchanged with the result
//  calc_cmd_out   out  [0:3] to calc1 reqN_cmd_in
//  calc_data_out  out  [0:31] to calc1 reqN_data_in
//  calc_resp_in   in   [0:1] from calc1 out_respN
//  calc_data_in   in   [0:31] from calc1 out_dataN
//  rsp_valid      out  1    result available
//  rsp_ready      in   1    consumer takes the result
//  rsp_resp       out  [0:1] captured calc1 response code (0 if timeout or no-op)
//  rsp_data       out  [0:31] captured calc1 data (0 unless rsp_resp==1)
//  rsp_tag        out  [0:1] tag of the completed request
//  rsp_timeout    out  1    result is a timeout, not a calc1 response
//  done_count     out  CNT_W results with rsp_resp!=0; saturates at all-ones
//  tmo_count      out  CNT_W timeouts; saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready=1; counters 0.
//   Reset in any state drops the in-flight request without returning a result.
//  FSM states and transitions:
//   IDLE: req_ready=1.
//    - Accept when req_valid&req_ready; latch cmd, op1, op2 and tag.
//    - cmd!=0 goes to OP1.
//    - cmd==0 goes to HOLD with resp=0, data=0, timeout=0. No calc1 traffic.
//   OP1: calc_cmd_out=cmd, calc_data_out=op1. Next state OP2.
//   OP2: calc_cmd_out=0, calc_data_out=op2. Wait counter cleared. Next state WAIT.
//   WAIT: calc_cmd_out=0, calc_data_out=0; counter increments each cycle.
//    - calc_resp_in!=0 sampled: capture resp and data, go to HOLD, bump done_count.
//    - Else counter reaches TIMEOUT: rsp_timeout=1, resp=0, data=0, go to HOLD,
//      bump tmo_count.
//    - A response on the same edge as expiry wins; it is not a timeout.
//   HOLD: rsp_valid=1; rsp_* held stable until rsp_ready. On rsp_valid&rsp_ready
//    go to IDLE. No combinational path from rsp_ready to req_ready: the next
//    accept is one cycle later at the earliest.
//  calc1 drive: calc_cmd_out and calc_data_out are registered, and are 0
//   outside OP1 and OP2.
//  calc_resp_in!=0 outside WAIT is ignored. No capture, no count.
//  Timing, edges relative to accept at E0:
//   - calc1 samples cmd+op1 at E1 and op2 at E2.
//   - A response sampled at Ek raises rsp_valid after Ek.
//   - With zero backpressure, throughput is one op per (4 + calc1 latency) cycles.
//  No arithmetic on operands; data passes through bit-exact, bit 0 = MSB.
// STRUCTURE
//  calc1_pkg holds the shared definitions:
//   - CMD_NOP/ADD/SUB/SHL/SHR
//   - RESP_NONE/OK/ERR/UNUSED
//   - the state encoding IDLE/OP1/OP2/WAIT/HOLD
//  Single flat module; the wait and stats counters are inline. No sub-module.
// TESTING
//  1 Hold reset 4 cycles, then release: req_ready=1, rsp_valid=0, calc_cmd_out=0, counters 0.
//  2 add 0x00000001 + 0x01FFFFFF, tag 2: calc1 sees cmd 1 then op2; rsp_resp=1,
//    rsp_data=0x02000000, rsp_tag=2, done_count=1.
//  3 add 0xFFFFFFFF + 0x00000001: rsp_resp=2 (overflow), rsp_data=0, rsp_timeout=0.
//  4 TIMEOUT=16, calc1 stub never responds: rsp_valid rises 16 cycles after OP2,
//    rsp_timeout=1, tmo_count=1.
//  5 rsp_ready low 5 cycles in HOLD: rsp_* stable and req_ready=0; release gives
//    1-cycle handshake, then IDLE.
//  6 Assert reset during WAIT, then apply a late calc1 response: no rsp_valid;
//    next add 3+4 returns rsp_data=7.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command and response codes, sequencer state
// encoding, and the latched request fields.
package calc1_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE   = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ERR    = 2'd2;
  localparam logic [1:0] RESP_UNUSED = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP1  = 3'd1,
    OP2  = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } seq_state_e;

  // cmd and op1 live in the calc1 drive registers from the accept edge,
  // so only the fields needed after OP1 are kept here.
  typedef struct packed {
    logic [31:0] op2;
    logic [1:0]  tag;
  } seq_req_t;

endpackage

// File: rtl/calc1_port_sequencer.sv
// Feeds one calc1 request port: accepts a whole operation, serialises it
// into calc1's two-cycle cmd/op1, op2 protocol, waits for the response (or
// a timeout) and hands the result back with its tag.
module calc1_port_sequencer
  import calc1_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [0:3]       req_cmd,
  input  logic [0:31]      req_op1,
  input  logic [0:31]      req_op2,
  input  logic [0:1]       req_tag,
  output logic [0:3]       calc_cmd_out,
  output logic [0:31]      calc_data_out,
  input  logic [0:1]       calc_resp_in,
  input  logic [0:31]      calc_data_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [0:1]       rsp_resp,
  output logic [0:31]      rsp_data,
  output logic [0:1]       rsp_tag,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] tmo_count
);

  // Last WAIT-cycle count value; expiry fires on the edge that would make it TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  seq_state_e  state_q, state_d;
  seq_req_t    req_q;
  logic [15:0] wait_cnt;
  logic        accept;
  logic        resp_hit;
  logic        expire;

  assign accept   = (state_q == IDLE) && req_valid;
  assign resp_hit = (state_q == WAIT) && (calc_resp_in != RESP_NONE);
  assign expire   = (state_q == WAIT) && !resp_hit && (wait_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge c_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; req_ready depends on state only.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_cmd != CMD_NOP) ? OP1 : HOLD;
      end
      OP1:  state_d = OP2;
      OP2:  state_d = WAIT;
      WAIT: if (resp_hit || expire) state_d = HOLD;
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the fields used after the first calc1 cycle.
  always_ff @(posedge c_clk) begin
    if (reset)       req_q <= '0;
    else if (accept) req_q <= '{op2: req_op2, tag: req_tag};
  end

  // calc1 drive registers: non-zero only while the state is OP1 or OP2.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      calc_cmd_out  <= '0;
      calc_data_out <= '0;
    end else begin
      calc_cmd_out  <= '0;
      calc_data_out <= '0;
      if (accept && (req_cmd != CMD_NOP)) begin
        calc_cmd_out  <= req_cmd;
        calc_data_out <= req_op1;
      end else if (state_q == OP1) begin
        calc_data_out <= req_q.op2;
      end
    end
  end

  // WAIT-cycle counter, cleared as op2 goes out.
  always_ff @(posedge c_clk) begin
    if (reset)                   wait_cnt <= '0;
    else if (state_q == OP2)     wait_cnt <= '0;
    else if (state_q == WAIT)    wait_cnt <= wait_cnt + 16'd1;
  end

  // Result registers: loaded on entry to HOLD, cleared once consumed.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      rsp_resp    <= '0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_timeout <= 1'b0;
    end else if (accept && (req_cmd == CMD_NOP)) begin
      rsp_resp    <= RESP_NONE;
      rsp_data    <= '0;
      rsp_tag     <= req_tag;
      rsp_timeout <= 1'b0;
    end else if (resp_hit) begin
      rsp_resp    <= calc_resp_in;
      rsp_data    <= (calc_resp_in == RESP_OK) ? calc_data_in : '0;
      rsp_tag     <= req_q.tag;
      rsp_timeout <= 1'b0;
    end else if (expire) begin
      rsp_resp    <= RESP_NONE;
      rsp_data    <= '0;
      rsp_tag     <= req_q.tag;
      rsp_timeout <= 1'b1;
    end else if ((state_q == HOLD) && rsp_ready) begin
      rsp_resp    <= '0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_timeout <= 1'b0;
    end
  end

  // Saturating completion and timeout statistics.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      done_count <= '0;
      tmo_count  <= '0;
    end else begin
      if (resp_hit && (done_count != '1)) done_count <= done_count + 1'b1;
      if (expire && (tmo_count != '1))    tmo_count  <= tmo_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_calc1_port_sequencer.sv
// Bench for calc1_port_sequencer: a behavioural calc1 stub with variable
// latency drives the response side; each operation's result is predicted
// from the calc1 arithmetic rules and the sequencer's return rules.
module tb_calc1_port_sequencer;

  localparam int TMO  = 16;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          c_clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [0:3]    req_cmd;
  logic [0:31]   req_op1;
  logic [0:31]   req_op2;
  logic [0:1]    req_tag;
  logic [0:3]    calc_cmd_out;
  logic [0:31]   calc_data_out;
  logic [0:1]    calc_resp_in;
  logic [0:31]   calc_data_in;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [0:1]    rsp_resp;
  logic [0:31]   rsp_data;
  logic [0:1]    rsp_tag;
  logic          rsp_timeout;
  logic [CW-1:0] done_count;
  logic [CW-1:0] tmo_count;

  calc1_port_sequencer #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .calc_cmd_out(calc_cmd_out), .calc_data_out(calc_data_out),
    .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_timeout(rsp_timeout),
    .done_count(done_count), .tmo_count(tmo_count)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // calc1 arithmetic: overflow/underflow and unknown commands give resp 2.
  function automatic void calc_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [1:0] r, output logic [31:0] d);
    logic [32:0] s;
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        if (!s[32]) begin r = 2'd1; d = s[31:0]; end
      end
      4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << b[4:0]; end
      4'd6: begin r = 2'd1; d = a >> b[4:0]; end
      default: ;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  // calc1 stub state
  int          stub_st = 0;
  int          stub_cd = 0;
  int          stub_n  = 0;
  int          stub_lat = 1;
  bit          stub_silent = 1'b0;
  bit          inject = 1'b0;
  logic [3:0]  seen_cmd;
  logic [31:0] seen_op1;
  logic [31:0] seen_op2;
  logic [3:0]  seen_c2;

  // The stub looks at the port on the falling edge (what calc1 will sample on
  // the next rising edge) and drives its response for exactly one cycle.
  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    calc_resp_in = '0;
    calc_data_in = '0;
    seen_cmd = '0; seen_op1 = '0; seen_op2 = '0; seen_c2 = '0;
    forever begin
      @(negedge c_clk);
      calc_resp_in = '0;
      calc_data_in = '0;
      if (reset) begin
        stub_st = 0;
      end else begin
        if (inject) begin
          calc_resp_in = 2'd1;
          calc_data_in = 32'h0000_0BAD;
        end
        case (stub_st)
          0: if (calc_cmd_out != 4'd0) begin
               seen_cmd = calc_cmd_out;
               seen_op1 = calc_data_out;
               stub_n++;
               stub_st = 1;
             end
          1: begin
               seen_c2  = calc_cmd_out;
               seen_op2 = calc_data_out;
               stub_cd  = stub_lat;
               stub_st  = stub_silent ? 0 : 2;
             end
          default: begin
               stub_cd--;
               if (stub_cd <= 0) begin
                 calc_model(seen_cmd, seen_op1, seen_op2, r, d);
                 calc_resp_in = r;
                 calc_data_in = (r == 2'd1) ? d : ($urandom | 32'd1);
                 stub_st = 0;
               end
             end
        endcase
      end
    end
  end

  int exp_done = 0;
  int exp_tmo  = 0;

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] t, input int lat, input bit silent, input int hold,
                       output logic [1:0] g_resp, output logic [31:0] g_data);
    logic [1:0]  er;
    logic [31:0] ed;
    bit          etmo;
    int          lat_exp;
    int          n0;
    int          k;
    stub_lat    = lat;
    stub_silent = silent;
    if (c == 4'd0) begin
      er = 2'd0; ed = 32'd0; etmo = 1'b0; lat_exp = 1;
    end else if (silent || lat > TMO) begin
      er = 2'd0; ed = 32'd0; etmo = 1'b1; lat_exp = TMO + 3;
    end else begin
      calc_model(c, a, b, er, ed);
      if (er != 2'd1) ed = 32'd0;
      etmo = 1'b0; lat_exp = lat + 3;
    end
    if (er != 2'd0) exp_done = sat(exp_done);
    if (etmo)       exp_tmo  = sat(exp_tmo);

    k = 0;
    while (!req_ready && k < 50) begin @(negedge c_clk); k++; end
    chk("req_ready_idle", req_ready, 1);
    n0 = stub_n;
    req_valid = 1'b1; req_cmd = c; req_op1 = a; req_op2 = b; req_tag = t;
    @(posedge c_clk);
    @(negedge c_clk);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 100) begin @(negedge c_clk); k++; end
    chk("rsp_latency", k, lat_exp);
    g_resp = rsp_resp;
    g_data = rsp_data;
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid_hold", rsp_valid, 1);
      chk("rsp_resp", rsp_resp, er);
      chk("rsp_data", rsp_data, ed);
      chk("rsp_tag", rsp_tag, t);
      chk("rsp_timeout", rsp_timeout, etmo);
      chk("req_ready_hold", req_ready, 0);
      chk("calc_cmd_hold", calc_cmd_out, 0);
      if (i < hold) @(negedge c_clk);
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
    chk("done_count", done_count, exp_done);
    chk("tmo_count", tmo_count, exp_tmo);
    if (c != 4'd0) begin
      chk("calc_seen_cmd", seen_cmd, c);
      chk("calc_seen_op1", seen_op1, a);
      chk("calc_seen_op2", seen_op2, b);
      chk("calc_seen_cmd2", seen_c2, 0);
    end else begin
      chk("nop_no_traffic", stub_n, n0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  gr;
    logic [31:0] gd;
    logic [3:0]  cmds [7];
    logic [31:0] edges [4];
    logic [3:0]  c;
    logic [31:0] a, b;
    cmds  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15};
    edges = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h8000_0000};
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_cmd = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;

    // reset state
    repeat (4) @(posedge c_clk);
    @(negedge c_clk);
    reset = 1'b0;
    @(negedge c_clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_calc_cmd", calc_cmd_out, 0);
    chk("rst_calc_data", calc_data_out, 0);
    chk("rst_done", done_count, 0);
    chk("rst_tmo", tmo_count, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // plain add
    do_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd2, 2, 1'b0, 0, gr, gd);
    chk("add_resp_const", gr, 1);
    chk("add_data_const", gd, 32'h0200_0000);
    chk("add_done_const", done_count, 1);

    // add overflow
    do_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd1, 3, 1'b0, 0, gr, gd);
    chk("ovf_resp_const", gr, 2);
    chk("ovf_data_const", gd, 0);

    // missing response
    do_op(4'd1, 32'd5, 32'd6, 2'd3, 1, 1'b1, 0, gr, gd);
    chk("tmo_count_const", tmo_count, 1);

    // backpressure in HOLD
    do_op(4'd2, 32'd100, 32'd58, 2'd0, 4, 1'b0, 5, gr, gd);

    // response on the expiry edge wins; one cycle later is a timeout
    do_op(4'd5, 32'h0000_00F0, 32'd4, 2'd1, TMO, 1'b0, 0, gr, gd);
    do_op(4'd6, 32'h8000_0000, 32'd31, 2'd2, TMO + 1, 1'b0, 1, gr, gd);

    // no-op takes no calc1 traffic
    do_op(4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 2'd3, 1, 1'b0, 2, gr, gd);

    // reset while waiting, then a late response
    stub_silent = 1'b1;
    req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'd9; req_op2 = 32'd9; req_tag = 2'd1;
    @(posedge c_clk);
    @(negedge c_clk);
    req_valid = 1'b0;
    repeat (5) @(negedge c_clk);
    reset = 1'b1;
    repeat (2) @(negedge c_clk);
    reset = 1'b0;
    exp_done = 0;
    exp_tmo  = 0;
    inject = 1'b1;
    @(negedge c_clk);
    inject = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_wait_no_rsp", rsp_valid, 0);
      @(negedge c_clk);
    end
    chk("rst_wait_done", done_count, 0);
    chk("rst_wait_tmo", tmo_count, 0);
    do_op(4'd1, 32'd3, 32'd4, 2'd0, 1, 1'b0, 0, gr, gd);
    chk("after_rst_data", gd, 7);

    // randomized operations; small counters also reach saturation
    for (int n = 0; n < 40; n++) begin
      c = cmds[$urandom_range(0, 6)];
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 1) == 0) b = b & 32'h0000_FFFF;
      do_op(c, a, b, 2'($urandom_range(0, 3)), $urandom_range(1, TMO + 2),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3), gr, gd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
